fp_sub_seq: RTL and testbench

- Multi-cycle IEEE 754 double-precision subtractor. Computes result = a - b.
- Uses a valid/ready handshake on both the input and output sides.
- Normalizes iteratively, one left shift per cycle, to keep area and timing small.
- Sits beside the combinational double adder in the FP datapath and serves the slow-path and shared-unit users.

---
 rtl/fp_sub_seq.sv | 199 +++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE double subtractor (result = a - b) with one-shift-per-cycle normalization.
// Optional macro FP_SUB_ROUND_EN keeps guard/round/sticky bits and adds a round-to-nearest-even state.
module fp_sub_seq #(
    parameter int EXP_W = 11,
    parameter int SIG_W = 52
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+SIG_W:0] a_in,
    input  logic [EXP_W+SIG_W:0] b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+SIG_W:0] result,
    output logic [5:0]           norm_shifts
);
`ifdef FP_SUB_ROUND_EN
    localparam int XW = 3;
`else
    localparam int XW = 0;
`endif
    localparam int FW = EXP_W + SIG_W + 1;
    localparam int W  = SIG_W + 3 + XW;
    localparam int HB = SIG_W + XW;
    localparam logic [EXP_W-1:0] EXP_INF = '1;
    localparam logic [EXP_W-1:0] EXP_TOP = {{(EXP_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    a_q, a_d, b_q, b_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [W-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [FW-1:0]    result_q, result_d;
    logic [5:0]       norm_shifts_q, norm_shifts_d;
    logic             out_valid_q, out_valid_d;

    logic             swap;
    logic [FW-1:0]    hi, lo;
    logic [EXP_W-1:0] diff;
    logic [W-1:0]     hi_sig, lo_sig, lo_shift;
    logic [W-1:0]     ta, tb, sum, mag;
`ifdef FP_SUB_ROUND_EN
    logic             round_up;
    logic [SIG_W+1:0] mant;
    logic [EXP_W-1:0] exp_r;
`endif

    always_comb begin
        // Alignment datapath: larger exponent goes to "a", smaller significand shifted right.
        swap     = a_q[FW-2:SIG_W] < b_q[FW-2:SIG_W];
        hi       = swap ? b_q : a_q;
        lo       = swap ? a_q : b_q;
        diff     = hi[FW-2:SIG_W] - lo[FW-2:SIG_W];
        hi_sig   = W'({|hi[FW-2:SIG_W], hi[SIG_W-1:0]}) << XW;
        lo_sig   = W'({|lo[FW-2:SIG_W], lo[SIG_W-1:0]}) << XW;
        lo_shift = (diff >= EXP_W'(W)) ? '0 : (lo_sig >> diff);
`ifdef FP_SUB_ROUND_EN
        if (diff >= EXP_W'(W))
            lo_shift[0] = |lo_sig;
        else
            lo_shift[0] = lo_shift[0] | (|(lo_sig & ((W'(1) << diff) - W'(1))));
`endif

        ta  = sa_q ? (~ma_q + W'(1)) : ma_q;
        tb  = sb_q ? (~mb_q + W'(1)) : mb_q;
        sum = ta + tb;
        mag = sum[W-1] ? (~sum + W'(1)) : sum;

`ifdef FP_SUB_ROUND_EN
        round_up = ma_q[XW-1] & ((|ma_q[XW-2:0]) | ma_q[XW]);
        mant     = {1'b0, ma_q[HB:XW]} + (SIG_W+2)'(round_up);
        exp_r    = exp_q + EXP_W'(mant[SIG_W+1]);
`endif

        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        sa_d          = sa_q;
        sb_d          = sb_q;
        exp_d         = exp_q;
        ma_d          = ma_q;
        mb_d          = mb_q;
        result_d      = result_q;
        norm_shifts_d = norm_shifts_q;
        out_valid_d   = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d           = a_in;
                    b_d           = {~b_in[FW-1], b_in[FW-2:0]};
                    norm_shifts_d = '0;
                    state_d       = S_ALIGN;
                end
            end
            S_ALIGN: begin
                sa_d    = hi[FW-1];
                sb_d    = lo[FW-1];
                exp_d   = hi[FW-2:SIG_W];
                ma_d    = hi_sig;
                mb_d    = lo_shift;
                state_d = S_ADD;
            end
            S_ADD: begin
                sa_d = sum[W-1];
                if (mag[HB+1]) begin
                    if (exp_q == EXP_TOP) begin
                        exp_d = EXP_INF;
                        ma_d  = W'(1) << HB;
                    end else begin
                        exp_d = exp_q + EXP_W'(1);
`ifdef FP_SUB_ROUND_EN
                        ma_d  = (mag >> 1) | W'(mag[0]);
`else
                        ma_d  = mag >> 1;
`endif
                    end
                end else begin
                    ma_d = mag;
                end
                state_d = S_NORM;
            end
            S_NORM: begin
                if (ma_q == '0) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (ma_q[HB]) begin
`ifdef FP_SUB_ROUND_EN
                    state_d = S_ROUND;
`else
                    result_d    = {sa_q, exp_q, ma_q[HB-1:XW]};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`endif
                end else if (exp_q == '0) begin
                    result_d    = '0;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    ma_d          = ma_q << 1;
                    exp_d         = exp_q - EXP_W'(1);
                    norm_shifts_d = norm_shifts_q + 6'd1;
                end
            end
`ifdef FP_SUB_ROUND_EN
            S_ROUND: begin
                // A mantissa carry-out leaves an all-zero fraction, so infinity falls out naturally.
                result_d    = {sa_q, exp_r, mant[SIG_W+1] ? mant[SIG_W:1] : mant[SIG_W-1:0]};
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            sa_q          <= 1'b0;
            sb_q          <= 1'b0;
            exp_q         <= '0;
            ma_q          <= '0;
            mb_q          <= '0;
            result_q      <= '0;
            norm_shifts_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            sa_q          <= sa_d;
            sb_q          <= sb_d;
            exp_q         <= exp_d;
            ma_q          <= ma_d;
            mb_q          <= mb_d;
            result_q      <= result_d;
            norm_shifts_q <= norm_shifts_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign norm_shifts = norm_shifts_q;
endmodule

// File: tb/tb_fp_sub_seq.sv
// Scoreboard bench for fp_sub_seq: expected result/shift count/latency queued at send, checked at output.
`timescale 1ns/1ps
module tb_fp_sub_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] result;
    logic [5:0]  norm_shifts;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int acc_cyc = 0;
    int dummy;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  ns;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    fp_sub_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .norm_shifts(norm_shifts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic [5:0] ens, input int elat,
                        output int waited);
        exp_t e;
        e.res = er; e.ns = ens; e.lat = elat; e.name = name;
        sb_q.push_back(e);
        a_in = a; b_in = b; in_valid = 1'b1;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1; waited++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout %s: in_ready=%b required 1", name, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc = cyc_cnt;
        in_valid = 1'b0;
        a_in = {$urandom, $urandom};
        b_in = {$urandom, $urandom};
        $display("send %s a=%h b=%h", name, a, b);
    endtask

    task automatic receive(input int hold);
        exp_t e;
        int waited;
        int lat;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 200) begin
            @(posedge clk); #1; waited++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
            if (sb_q.size() > 0) e = sb_q.pop_front();
            return;
        end
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: result=%h with empty scoreboard", result);
            return;
        end
        e = sb_q.pop_front();
        lat = cyc_cnt - acc_cyc + 1;
        total++;
        if (result !== e.res) begin
            bad++; $display("FAIL result %s: got %h required %h", e.name, result, e.res);
        end
        total++;
        if (norm_shifts !== e.ns) begin
            bad++; $display("FAIL norm_shifts %s: got %0d required %0d", e.name, norm_shifts, e.ns);
        end
        total++;
        if (lat != e.lat) begin
            bad++; $display("FAIL latency %s: got %0d required %0d", e.name, lat, e.lat);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL busy_ready %s: in_ready=%b required 0", e.name, in_ready);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || result !== e.res || norm_shifts !== e.ns || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold %s cycle %0d: valid=%b result=%h ns=%0d ready=%b required 1/%h/%0d/0",
                         e.name, i, out_valid, result, norm_shifts, in_ready, e.res, e.ns);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL release %s: valid=%b ready=%b required 0/1", e.name, out_valid, in_ready);
        end
        $display("recv %s result=%h ns=%0d lat=%0d", e.name, result, norm_shifts, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0 || norm_shifts !== 6'd0) begin
            bad++;
            $display("FAIL reset_state: ready=%b valid=%b result=%h ns=%0d required 1/0/0/0",
                     in_ready, out_valid, result, norm_shifts);
        end
        $display("reset state checked");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send("3-1",   64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6'd0, 4, dummy); receive(0);
        send("1-1",   64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 6'd0, 4, dummy); receive(0);
        send("1-3",   64'h3FF0000000000000, 64'h4008000000000000, 64'hC000000000000000, 6'd0, 4, dummy); receive(0);
        send("1-(-1)",64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 6'd0, 4, dummy); receive(0);
        send("1-0.75",64'h3FF0000000000000, 64'h3FE8000000000000, 64'h3FD0000000000000, 6'd2, 6, dummy); receive(0);
        send("-1-(-1)",64'hBFF0000000000000,64'hBFF0000000000000, 64'h0000000000000000, 6'd0, 4, dummy); receive(0);
    endtask

    task automatic test_boundary();
        send("cancel", 64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h3CB0000000000000, 6'd52, 56, dummy); receive(0);
        send("bigdiff",64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 6'd0, 4, dummy); receive(0);
        send("ovf_inf",64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 6'd0, 4, dummy); receive(0);
        send("undflow",64'h0010000000000001, 64'h0010000000000000, 64'h0000000000000000, 6'd1, 5, dummy); receive(0);
    endtask

    task automatic test_back_to_back();
        int waited;
        send("bp_3-1", 64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6'd0, 4, dummy);
        receive(10);
        send("b2b_2.5-0.5", 64'h4004000000000000, 64'h3FE0000000000000, 64'h4000000000000000, 6'd0, 4, waited);
        total++;
        if (waited != 0) begin
            bad++; $display("FAIL b2b_accept: waited %0d cycles required 0", waited);
        end
        receive(0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        send("rst_cancel", 64'h3FF0000000000000, 64'h3FEFFFFFFFFFFFFF, 64'h3CB0000000000000, 6'd52, 56, dummy);
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL mid_norm: valid=%b ready=%b required 0/0", out_valid, in_ready);
        end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 64'h0 || norm_shifts !== 6'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: valid=%b result=%h ns=%0d ready=%b required 0/0/0/1",
                     out_valid, result, norm_shifts, in_ready);
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        $display("reset asserted mid-normalization");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send("post_rst_3-1", 64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 6'd0, 4, dummy);
        receive(0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
